// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg: shared opcode/state enums and run-length default for the ALU response checker
package alu_chk_pkg;
  localparam int DEF_NUM_VEC = 128;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NAND, ALU_SHL, ALU_SRL
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden ALU producing expected result and carry/borrow
module alu_ref_model import alu_chk_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   sel,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] r;
  // {co,s} per opcode; logic ops never produce a carry
  always_comb begin
    r = '0;
    case (alu_op_e'(sel))
      ALU_ADD:  r = {1'b0, a} + {1'b0, b};
      ALU_SUB:  r = {1'b0, a} - {1'b0, b};
      ALU_AND:  r = {1'b0, a & b};
      ALU_OR:   r = {1'b0, a | b};
      ALU_XOR:  r = {1'b0, a ^ b};
      ALU_NAND: r = {1'b0, ~(a & b)};
      ALU_SHL:  r = {a[N-1], a[N-2:0], 1'b0};
      ALU_SRL:  r = {a[0], 1'b0, a[N-1:1]};
      default:  r = '0;
    endcase
  end
  assign {co, s} = r;
endmodule

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: checks observed ALU responses against a reference over a fixed-length run
module alu_resp_checker import alu_chk_pkg::*; #(
  parameter int N       = 4,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [2:0]       sel,
  input  logic [N-1:0]     s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] x_cnt,
  output logic             fail_valid,
  output logic [N-1:0]     fail_a,
  output logic [N-1:0]     fail_b,
  output logic [2:0]       fail_sel,
  output logic [N-1:0]     fail_s,
  output logic             fail_co
);
  localparam int TW = $clog2(NUM_VEC + 1);
  localparam logic [TW-1:0] LAST = TW'(NUM_VEC - 1);
  state_e st_q;
  logic cap_v_q, cap_x_q, cap_co_q;
  logic [N-1:0] cap_a_q, cap_b_q, cap_s_q;
  logic [2:0] cap_sel_q;
  logic [TW-1:0] tot_q;
  logic [CNT_W-1:0] chk_q, err_q, x_q;
  logic fv_q, fco_q;
  logic [N-1:0] fa_q, fb_q, fs_q;
  logic [2:0] fsel_q;
  logic [N-1:0] exp_s;
  logic exp_co, mism, last_res;
  alu_ref_model #(.N(N)) u_ref (
    .a(cap_a_q), .b(cap_b_q), .sel(cap_sel_q), .s(exp_s), .co(exp_co)
  );
  // X/Z on the observed response also counts as a mismatch
  assign mism = {cap_co_q, cap_s_q} !== {exp_co, exp_s};
  assign last_res = cap_v_q && tot_q == LAST;
  // run FSM, capture stage, saturating counters and first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      cap_v_q <= 1'b0;
      cap_x_q <= 1'b0;
      cap_a_q <= '0;
      cap_b_q <= '0;
      cap_sel_q <= '0;
      cap_s_q <= '0;
      cap_co_q <= 1'b0;
      tot_q <= '0;
      chk_q <= '0;
      err_q <= '0;
      x_q <= '0;
      fv_q <= 1'b0;
      fa_q <= '0;
      fb_q <= '0;
      fsel_q <= '0;
      fs_q <= '0;
      fco_q <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE, ST_DONE: begin
          cap_v_q <= 1'b0;
          if (start) begin
            st_q <= ST_RUN;
            tot_q <= '0;
            chk_q <= '0;
            err_q <= '0;
            x_q <= '0;
            fv_q <= 1'b0;
            fa_q <= '0;
            fb_q <= '0;
            fsel_q <= '0;
            fs_q <= '0;
            fco_q <= 1'b0;
          end
        end
        ST_RUN: begin
          cap_v_q <= in_valid && !last_res;
          if (in_valid) begin
            cap_x_q <= $isunknown({a, b, sel});
            cap_a_q <= a;
            cap_b_q <= b;
            cap_sel_q <= sel;
            cap_s_q <= s;
            cap_co_q <= co;
          end
          if (cap_v_q) begin
            tot_q <= tot_q + 1'b1;
            if (last_res) st_q <= ST_DONE;
            if (cap_x_q) x_q <= x_q == '1 ? x_q : x_q + 1'b1;
            else begin
              chk_q <= chk_q == '1 ? chk_q : chk_q + 1'b1;
              if (mism) begin
                err_q <= err_q == '1 ? err_q : err_q + 1'b1;
                if (!fv_q) begin
                  fv_q <= 1'b1;
                  fa_q <= cap_a_q;
                  fb_q <= cap_b_q;
                  fsel_q <= cap_sel_q;
                  fs_q <= cap_s_q;
                  fco_q <= cap_co_q;
                end
              end
            end
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end
  assign busy = st_q == ST_RUN;
  assign done = st_q == ST_DONE;
  assign pass = done && err_q == '0;
  assign chk_cnt = chk_q;
  assign err_cnt = err_q;
  assign x_cnt = x_q;
  assign fail_valid = fv_q;
  assign fail_a = fa_q;
  assign fail_b = fb_q;
  assign fail_sel = fsel_q;
  assign fail_s = fs_q;
  assign fail_co = fco_q;
endmodule

// File: tb/tb_alu_resp_checker.sv
// tb_alu_resp_checker: directed self-checking bench for alu_resp_checker
module tb_alu_resp_checker;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, co = 0;
  logic [3:0] a = 0, b = 0, s = 0;
  logic [2:0] sel = 0;
  logic busy, done, pass, fail_valid, fail_co;
  logic [7:0] chk_cnt, err_cnt, x_cnt;
  logic [3:0] fail_a, fail_b, fail_s;
  logic [2:0] fail_sel;
  logic busy4, done4, pass4, fv4, fco4;
  logic [3:0] chk4, err4, x4, fa4, fb4, fs4;
  logic [2:0] fsel4;
  int total = 0, bad = 0;
  logic probe;
  always #5 clk = ~clk;
  alu_resp_checker dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
    .s(s), .co(co), .busy(busy), .done(done), .pass(pass), .chk_cnt(chk_cnt),
    .err_cnt(err_cnt), .x_cnt(x_cnt), .fail_valid(fail_valid), .fail_a(fail_a),
    .fail_b(fail_b), .fail_sel(fail_sel), .fail_s(fail_s), .fail_co(fail_co)
  );
  alu_resp_checker #(.NUM_VEC(20), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
    .s(s), .co(co), .busy(busy4), .done(done4), .pass(pass4), .chk_cnt(chk4),
    .err_cnt(err4), .x_cnt(x4), .fail_valid(fv4), .fail_a(fa4),
    .fail_b(fb4), .fail_sel(fsel4), .fail_s(fs4), .fail_co(fco4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] ref_out(input int va, input int vb, input int vs);
    int r;
    case (vs)
      0: r = va + vb;
      1: r = (va - vb) & 31;
      2: r = va & vb;
      3: r = va | vb;
      4: r = va ^ vb;
      5: r = ~(va & vb) & 15;
      6: r = ((va * 2) & 15) | ((va / 8) << 4);
      default: r = (va / 2) | ((va % 2) << 4);
    endcase
    return r[4:0];
  endfunction
  task automatic vec(input logic [3:0] va, input logic [3:0] vb, input logic [2:0] vs,
                     input logic [3:0] ss, input logic sc);
    in_valid = 1; a = va; b = vb; sel = vs; s = ss; co = sc;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic run_good(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      int k, va, vb, vs;
      logic [4:0] e;
      k = i + off; vs = (k / 16) % 8; va = k % 16; vb = (k * 5 + 3) % 16;
      e = ref_out(va, vb, vs);
      vec(4'(va), 4'(vb), 3'(vs), e[3:0], e[4]);
    end
  endtask
  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask
  initial begin
    probe = 1'bx;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_chk", chk_cnt, 0); chk("rst_err", err_cnt, 0); chk("rst_x", x_cnt, 0);
    chk("rst_fv", fail_valid, 0);
    start = 1;
    @(negedge clk);
    chk("rst_over_start", busy, 0);
    rst = 0;
    @(negedge clk);
    start = 0;
    chk("start_busy", busy, 1);
    run_good(128, 0);
    wait_done("full_done");
    chk("full_pass", pass, 1); chk("full_chk", chk_cnt, 128);
    chk("full_err", err_cnt, 0); chk("full_x", x_cnt, 0); chk("full_busy", busy, 0);
    // single carry mismatch, also checks one-cycle resolution latency
    go();
    vec(4'hF, 4'h1, 3'd0, 4'h0, 1'b0);
    chk("lat_err0", err_cnt, 0);
    @(negedge clk);
    chk("lat_err1", err_cnt, 1);
    run_good(127, 5);
    wait_done("m1_done");
    chk("m1_err", err_cnt, 1); chk("m1_fv", fail_valid, 1); chk("m1_sel", fail_sel, 0);
    chk("m1_a", fail_a, 4'hF); chk("m1_b", fail_b, 4'h1); chk("m1_s", fail_s, 0);
    chk("m1_co", fail_co, 0); chk("m1_pass", pass, 0); chk("m1_chk", chk_cnt, 128);
    // restart from DONE clears; two mismatches keep the first; start in RUN ignored
    go();
    chk("re_err", err_cnt, 0); chk("re_fv", fail_valid, 0); chk("re_fsel", fail_sel, 0);
    vec(4'hC, 4'hA, 3'd2, 4'h9, 1'b0);
    vec(4'h5, 4'h0, 3'd7, 4'h2, 1'b0);
    go();
    chk("m2_mid_err", err_cnt, 2);
    chk("m2_mid_busy", busy, 1);
    run_good(126, 17);
    wait_done("m2_done");
    chk("m2_err", err_cnt, 2); chk("m2_sel", fail_sel, 2); chk("m2_s", fail_s, 9);
    chk("m2_chk", chk_cnt, 128);
    // unknown operands or opcode only exercisable on a four-state simulator
    if (probe === 1'bx) begin
      go();
      vec(4'bx101, 4'b0101, 3'd0, 4'hA, 1'b0);
      vec(4'h3, 4'h2, 3'b11x, 4'h0, 1'b0);
      run_good(126, 9);
      wait_done("x_done");
      chk("x_cnt", x_cnt, 2); chk("x_err", err_cnt, 0); chk("x_chk", chk_cnt, 126);
    end
    // reset mid-run with a vector in the capture stage
    go();
    run_good(40, 3);
    chk("pre_rst_chk", chk_cnt, 39);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mr_busy", busy, 0); chk("mr_done", done, 0); chk("mr_chk", chk_cnt, 0);
    chk("mr_err", err_cnt, 0); chk("mr_x", x_cnt, 0);
    @(negedge clk);
    chk("mr_idle", busy, 0);
    go();
    run_good(128, 30);
    wait_done("mr_full_done");
    chk("mr_full_chk", chk_cnt, 128); chk("mr_full_pass", pass, 1);
    // saturation on the narrow-counter instance
    go();
    for (int i = 0; i < 20; i++) vec(4'(i), 4'h3, 3'd3, 4'(i) ^ 4'hF, 1'b1);
    @(negedge clk);
    chk("sat_done", done4, 1); chk("sat_err", err4, 15); chk("sat_chk", chk4, 15);
    chk("sat_wide_err", err_cnt, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
